// File: rtl/icm_mapping_lookup_arb_if.sv
// Bundle of the requester-side and mapping-table-side handshake signals of the
// ICM mapping lookup arbiter.
//   master : arbiter view. It accepts requester lookups and returns routed responses.
//            It issues lookups to the mapping table and accepts its responses.
//   slave  : environment view. This is the requesters plus the mapping table.
// Requester i owns bit i of each per-requester vector.
// It also owns slice [i*HEAD_WIDTH +: HEAD_WIDTH] of req_head.
interface icm_mapping_lookup_arb_if #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned HEAD_WIDTH     = 20,
  parameter int unsigned ICM_ADDR_WIDTH = 64,
  parameter int unsigned PHY_ADDR_WIDTH = 64
);
  // Requester side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*HEAD_WIDTH-1:0] req_head;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid_out;
  logic [ICM_ADDR_WIDTH-1:0]     rsp_icm_addr_out;
  logic [PHY_ADDR_WIDTH-1:0]     rsp_phy_addr_out;
  logic [NUM_REQ-1:0]            rsp_ready_in;

  // Mapping-table side
  logic                          lookup_valid;
  logic [HEAD_WIDTH-1:0]         lookup_head;
  logic                          lookup_ready;
  logic                          rsp_valid;
  logic [ICM_ADDR_WIDTH-1:0]     rsp_icm_addr;
  logic [PHY_ADDR_WIDTH-1:0]     rsp_phy_addr;
  logic                          rsp_ready;

  modport master (
    input  req_valid,
    input  req_head,
    output req_ready,
    output rsp_valid_out,
    output rsp_icm_addr_out,
    output rsp_phy_addr_out,
    input  rsp_ready_in,
    output lookup_valid,
    output lookup_head,
    input  lookup_ready,
    input  rsp_valid,
    input  rsp_icm_addr,
    input  rsp_phy_addr,
    output rsp_ready
  );

  modport slave (
    output req_valid,
    output req_head,
    input  req_ready,
    input  rsp_valid_out,
    input  rsp_icm_addr_out,
    input  rsp_phy_addr_out,
    output rsp_ready_in,
    input  lookup_valid,
    input  lookup_head,
    output lookup_ready,
    output rsp_valid,
    output rsp_icm_addr,
    output rsp_phy_addr,
    input  rsp_ready
  );
endinterface

// File: rtl/icm_mapping_lookup_arb.sv
// Shares a single ICM address-translation port among NUM_REQ requester threads.
// Examples of requester threads are MTT write and MPT write.
// Requesters are picked round-robin, and only one lookup is ever outstanding.
// The mapping-table response is routed back only to the requester that issued the lookup.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   bus        icm_mapping_lookup_arb_if.master.
//              It carries the requester handshakes and the mapping-table handshakes.
//   grant_idx  current or last granted requester (debug), zero-extended to 3 bits
module icm_mapping_lookup_arb #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned HEAD_WIDTH     = 20,
  parameter int unsigned ICM_ADDR_WIDTH = 64,
  parameter int unsigned PHY_ADDR_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  icm_mapping_lookup_arb_if.master         bus,
  output logic [2:0]                       grant_idx
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
    $error("icm_mapping_lookup_arb: NUM_REQ must be in 2..8");
  end

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRsp
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] last_grant_q, last_grant_d;

  logic [7:0]            valid_ext;
  logic [2:0]            pick;
  logic                  pick_found;
  logic [NUM_REQ-1:0]    grant_oh;
  logic [HEAD_WIDTH-1:0] head_sel;

  // Padding to 8 bits lets a 3-bit index address the valid vector for any NUM_REQ.
  assign valid_ext = 8'(bus.req_valid);

  // Round-robin pick: the first valid requester after last_grant, wrapping around.
  // i runs to NUM_REQ so last_grant itself is considered last.
  always_comb begin : rr_pick
    logic [2:0] idx;
    idx        = '0;
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 3'((32'(last_grant_q) + i) % NUM_REQ);
      if (!pick_found && valid_ext[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  // Decode the registered grant into a one-hot mask and a head mux.
  always_comb begin : grant_decode
    grant_oh = '0;
    head_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        grant_oh[i] = 1'b1;
        head_sel    = bus.req_head[i*HEAD_WIDTH +: HEAD_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= 3'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin : fsm_comb
    state_d              = state_q;
    grant_d              = grant_q;
    last_grant_d         = last_grant_q;
    bus.req_ready        = '0;
    bus.rsp_valid_out    = '0;
    bus.rsp_icm_addr_out = '0;
    bus.rsp_phy_addr_out = '0;
    bus.lookup_valid     = 1'b0;
    bus.lookup_head      = '0;
    bus.rsp_ready        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Arbitration only happens here.
        // The grant then stays fixed until the response completes.
        if (pick_found) begin
          grant_d = pick;
          state_d = StReq;
        end
      end

      StReq: begin
        bus.lookup_valid = 1'b1;
        bus.lookup_head  = head_sel;
        bus.req_ready    = grant_oh & {NUM_REQ{bus.lookup_ready}};
        if (bus.lookup_ready) begin
          state_d = StRsp;
        end
      end

      StRsp: begin
        bus.rsp_valid_out    = grant_oh & {NUM_REQ{bus.rsp_valid}};
        bus.rsp_icm_addr_out = bus.rsp_icm_addr;
        bus.rsp_phy_addr_out = bus.rsp_phy_addr;
        bus.rsp_ready        = |(bus.rsp_ready_in & grant_oh);
        if (bus.rsp_valid && bus.rsp_ready) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign grant_idx = grant_q;

endmodule

// File: tb/tb_icm_mapping_lookup_arb.sv
module tb_icm_mapping_lookup_arb;
  localparam int unsigned NR = 3;
  localparam int unsigned HW = 20;
  localparam int unsigned IW = 64;
  localparam int unsigned PW = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] grant_idx;

  icm_mapping_lookup_arb_if #(
    .NUM_REQ(NR), .HEAD_WIDTH(HW), .ICM_ADDR_WIDTH(IW), .PHY_ADDR_WIDTH(PW)
  ) bus ();

  icm_mapping_lookup_arb #(
    .NUM_REQ(NR), .HEAD_WIDTH(HW), .ICM_ADDR_WIDTH(IW), .PHY_ADDR_WIDTH(PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]    g;
    logic [HW-1:0] h;
  } lk_t;
  typedef struct {
    logic [2:0]    g;
    logic [IW-1:0] icm;
    logic [PW-1:0] phy;
  } rs_t;

  lk_t lk_q[$];
  rs_t rs_q[$];
  lk_t lk_e;
  rs_t rs_e;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [NR-1:0] onehot(input logic [2:0] g);
    logic [NR-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Scoreboard monitor: pops an expectation on every handshake the DUT completes.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.lookup_valid && bus.lookup_ready) begin
        if (lk_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL lookup_unexpected: got head 0x%0h expected no lookup", bus.lookup_head);
        end else begin
          lk_e = lk_q.pop_front();
          chk("lookup_grant_idx", 64'(grant_idx), 64'(lk_e.g));
          chk("lookup_head", 64'(bus.lookup_head), 64'(lk_e.h));
          chk("lookup_req_ready", 64'(bus.req_ready), 64'(onehot(lk_e.g)));
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (rs_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid_out 0x%0h expected no response",
                   bus.rsp_valid_out);
        end else begin
          rs_e = rs_q.pop_front();
          chk("rsp_grant_idx", 64'(grant_idx), 64'(rs_e.g));
          chk("rsp_valid_out", 64'(bus.rsp_valid_out), 64'(onehot(rs_e.g)));
          chk("rsp_icm_addr_out", bus.rsp_icm_addr_out, rs_e.icm);
          chk("rsp_phy_addr_out", bus.rsp_phy_addr_out, rs_e.phy);
        end
      end
    end
  end

  task automatic set_head(input int i, input logic [HW-1:0] h);
    bus.req_head[i*HW +: HW] = h;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid    = '0;
    bus.lookup_ready = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_ready_in = '0;
    bus.rsp_icm_addr = '0;
    bus.rsp_phy_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Bounded wait for lookup_valid, sampling 1 time unit after the clock edge.
  task automatic wait_lookup(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (!bus.lookup_valid) begin
      if (n >= 20) begin
        checks++;
        errors++;
        $display("FAIL wait_lookup: got no lookup_valid expected one within 20 cycles");
        ok = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // One full transaction, called from posedge+1.
  // Pushes the expectations, optionally stalls each phase, then completes both handshakes.
  task automatic serve(input logic [2:0] g, input logic [HW-1:0] h, input logic [IW-1:0] icm,
                       input logic [PW-1:0] phy, input int lstall, input int rstall,
                       input bit drop);
    bit ok;
    lk_q.push_back('{g: g, h: h});
    rs_q.push_back('{g: g, icm: icm, phy: phy});
    wait_lookup(ok);
    if (!ok) return;
    // An early table response during the lookup stall must be ignored.
    if (lstall > 0) begin
      bus.rsp_valid = 1'b1;
      #1;
    end
    repeat (lstall) begin
      chk("stall_lookup_valid", 64'(bus.lookup_valid), 64'd1);
      chk("stall_lookup_head", 64'(bus.lookup_head), 64'(h));
      chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
      chk("early_rsp_ready", 64'(bus.rsp_ready), 64'd0);
      chk("early_rsp_valid_out", 64'(bus.rsp_valid_out), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.rsp_valid    = 1'b0;
    bus.lookup_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.lookup_ready = 1'b0;
    if (drop) bus.req_valid[g] = 1'b0;
    bus.rsp_valid    = 1'b1;
    bus.rsp_icm_addr = icm;
    bus.rsp_phy_addr = phy;
    bus.rsp_ready_in = '0;
    repeat (rstall) begin
      #1;
      chk("rstall_rsp_ready", 64'(bus.rsp_ready), 64'd0);
      chk("rstall_rsp_valid_out", 64'(bus.rsp_valid_out), 64'(onehot(g)));
      chk("rstall_icm", bus.rsp_icm_addr_out, icm);
      chk("rstall_phy", bus.rsp_phy_addr_out, phy);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready_in = onehot(g);
    @(posedge clk);
    #1;
    bus.rsp_valid    = 1'b0;
    bus.rsp_ready_in = '0;
    bus.rsp_icm_addr = '0;
    bus.rsp_phy_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    bus.req_head = '0;
    do_reset();

    // Reset state, checked during a second reset pulse.
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_lookup_valid", 64'(bus.lookup_valid), 64'd0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_rsp_valid_out", 64'(bus.rsp_valid_out), 64'd0);
    chk("reset_rsp_ready", 64'(bus.rsp_ready), 64'd0);
    chk("reset_grant_idx", 64'(grant_idx), 64'd0);
    rst = 1'b0;

    // T1: single requester 1, with a one-cycle latency and no lookahead.
    set_head(1, 20'h00123);
    bus.req_valid = 3'b010;
    @(negedge clk);
    chk("t1_no_lookahead", 64'(bus.lookup_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_lookup_valid_n1", 64'(bus.lookup_valid), 64'd1);
    serve(3'd1, 20'h00123, 64'h1000, 64'hABC0, 0, 0, 1'b1);

    // T2: tie right after reset. Requester 0 is served first, then requester 1.
    do_reset();
    set_head(0, 20'h0A0A0);
    set_head(1, 20'h0B0B0);
    bus.req_valid = 3'b011;
    serve(3'd0, 20'h0A0A0, 64'h2000, 64'h3000, 0, 0, 1'b1);
    serve(3'd1, 20'h0B0B0, 64'h2100, 64'h3100, 0, 0, 1'b1);

    // T3: fairness with all three requesters continuously valid.
    do_reset();
    set_head(0, 20'h11111);
    set_head(1, 20'h22222);
    set_head(2, 20'h33333);
    bus.req_valid = 3'b111;
    serve(3'd0, 20'h11111, 64'h4000, 64'h5000, 0, 0, 1'b0);
    serve(3'd1, 20'h22222, 64'h4001, 64'h5001, 0, 0, 1'b0);
    serve(3'd2, 20'h33333, 64'h4002, 64'h5002, 0, 0, 1'b0);
    serve(3'd0, 20'h11111, 64'h4003, 64'h5003, 0, 0, 1'b0);
    serve(3'd1, 20'h22222, 64'h4004, 64'h5004, 0, 0, 1'b0);
    serve(3'd2, 20'h33333, 64'h4005, 64'h5005, 0, 0, 1'b0);

    // T4: lookup backpressure for 5 cycles on requester 2.
    bus.req_valid = 3'b100;
    set_head(2, 20'hBEEF1);
    serve(3'd2, 20'hBEEF1, 64'hDEAD_0000, 64'hBEEF_0000, 5, 0, 1'b1);

    // T5: response stall for 3 cycles on requester 0.
    set_head(0, 20'h55555);
    bus.req_valid = 3'b001;
    serve(3'd0, 20'h55555, 64'hCAFE_F00D_0000_1000, 64'h0123_4567_89AB_CDE0, 0, 3, 1'b1);

    // T6: reset while in RSP abandons the transaction and restores priority to requester 0.
    set_head(1, 20'h00777);
    bus.req_valid = 3'b010;
    lk_q.push_back('{g: 3'd1, h: 20'h00777});
    wait_lookup(ok);
    bus.lookup_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.lookup_ready = 1'b0;
    bus.rsp_valid    = 1'b1;
    bus.rsp_icm_addr = 64'h7777;
    bus.rsp_phy_addr = 64'h8888;
    #1;
    chk("t6_in_rsp_valid_out", 64'(bus.rsp_valid_out), 64'(3'b010));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_lookup_valid", 64'(bus.lookup_valid), 64'd0);
    chk("t6_rst_rsp_valid_out", 64'(bus.rsp_valid_out), 64'd0);
    chk("t6_rst_rsp_ready", 64'(bus.rsp_ready), 64'd0);
    chk("t6_rst_icm", bus.rsp_icm_addr_out, 64'd0);
    chk("t6_rst_phy", bus.rsp_phy_addr_out, 64'd0);
    chk("t6_rst_grant_idx", 64'(grant_idx), 64'd0);
    bus.rsp_valid    = 1'b0;
    bus.rsp_icm_addr = '0;
    bus.rsp_phy_addr = '0;
    set_head(0, 20'h0C0C0);
    set_head(2, 20'h0E0E0);
    bus.req_valid = 3'b111;
    rst = 1'b0;
    serve(3'd0, 20'h0C0C0, 64'h9000, 64'h9100, 0, 0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("lookup_queue_drained", 64'(lk_q.size()), 64'd0);
    chk("rsp_queue_drained", 64'(rs_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
